flo_timed_bufs: RTL and testbench

- Parametrised bank of per-channel timed output buffers for the flo sequencer; successor to the fixed 24×16-bit buffer stage inside the sequencer core.
- Accepts timed words (channel, delay, data) from the instruction decoder; each channel has its own FIFO and countdown timer, so words issued at different times can be released on the same cycle.
- Adds configurable width, depth and channel count, an optional backpressure mode, per-channel flush, a global hold, and immediate (bypass) writes.

---
 rtl/flo_timed_bufs.sv | 207 ++++++++++++++++++++
 tb/tb_flo_timed_bufs.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flo_timed_bufs.sv
// Per-channel timed output buffers for the flo sequencer: FIFO plus countdown timer per channel.
// Optional occupancy/busy outputs are enabled by defining FLO_TIMED_BUFS_OCC_EN.
module flo_timed_bufs #(
   parameter  int NCH          = 24,
   parameter  int DATA_W       = 16,
   parameter  int DLY_W        = 8,
   parameter  int DEPTH        = 4,
   parameter  int BACKPRESSURE = 0,
   localparam int CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                    S_AXI_ACLK,
   input  logic                    S_AXI_ARESETN,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [CH_W-1:0]         in_chan_i,
   input  logic [DLY_W-1:0]        in_delay_i,
   input  logic [DATA_W-1:0]       in_data_i,
   input  logic                    in_imm_i,
   input  logic                    hold_i,
   input  logic [NCH-1:0]          flush_i,
   input  logic                    err_clr_i,
   output logic [NCH*DATA_W-1:0]   data_o,
   output logic [NCH-1:0]          stb_o,
   output logic [NCH-1:0]          ovf_o,
   output logic                    badch_o
`ifdef FLO_TIMED_BUFS_OCC_EN
   ,
   output logic [NCH*($clog2(DEPTH)+1)-1:0] occ_o,
   output logic                    busy_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } tstate_t;

   logic           acc;
   logic           chan_ok;
   logic           blocked;
   logic [NCH-1:0] blk_v;

   assign chan_ok = ({1'b0, in_chan_i} < (CH_W+1)'(NCH));
   assign acc     = in_valid_i && in_ready_o;

   // A channel blocks only when its FIFO is full and nothing pops on this edge.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      blocked = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (in_chan_i == CH_W'(k) && blk_v[k]) blocked = 1'b1;
      end
   end

   assign in_ready_o = (BACKPRESSURE == 0) || in_imm_i || !blocked;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         badch_o <= 1'b0;
      end else if (acc && !chan_ok) begin
         badch_o <= 1'b1;
      end else if (err_clr_i) begin
         badch_o <= 1'b0;
      end
   end

`ifdef FLO_TIMED_BUFS_OCC_EN
   logic [NCH-1:0] busy_v;
   assign busy_o = |busy_v;
`endif

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [DLY_W+DATA_W-1:0] mem [DEPTH];
      logic [AW-1:0]           wp_q, rp_q;
      logic [CW-1:0]           cnt_q;
      tstate_t                 st_q, st_d;
      logic [DLY_W-1:0]        tmr_q, tmr_d;
      logic [DATA_W-1:0]       tdat_q, tdat_d;
      logic [DATA_W-1:0]       out_q;
      logic                    stb_q, ovf_q;
      logic [DLY_W-1:0]        head_dly;
      logic [DATA_W-1:0]       head_dat;
      logic hit, flush, imm, empty, full;
      logic pop_base, rel_base, pop, rel, wr, ovf_set;

      assign hit   = acc && chan_ok && (in_chan_i == CH_W'(k));
      assign flush = flush_i[k];
      assign imm   = hit && in_imm_i && !flush;
      assign empty = (cnt_q == '0);
      assign full  = (cnt_q == CW'(DEPTH));

      assign {head_dly, head_dat} = mem[rp_q];

      // Base terms exclude the immediate write so in_ready_o never depends on in_valid_i.
      assign pop_base = !flush && !hold_i && !empty && (st_q == IDLE || tmr_q == '0);
      assign rel_base = !flush && !hold_i && (st_q == COUNT) && (tmr_q == '0);
      assign pop      = pop_base && !imm;
      assign rel      = rel_base && !imm;
      assign wr       = hit && !in_imm_i && !flush && (!full || pop);
      assign ovf_set  = hit && !in_imm_i && !flush && full && !pop;
      assign blk_v[k] = full && !pop_base;

      // NOTE: the FIFO storage has no reset; only pointers and count define its contents.
      always_ff @(posedge S_AXI_ACLK) begin
         if (wr) mem[wp_q] <= {in_delay_i, in_data_i};
      end

      always_comb begin
         st_d   = st_q;
         tmr_d  = tmr_q;
         tdat_d = tdat_q;
         if (flush || imm) begin
            st_d  = IDLE;
            tmr_d = '0;
         end else if (!hold_i) begin
            case (st_q)
               IDLE: begin
                  if (!empty) begin
                     st_d   = COUNT;
                     tmr_d  = head_dly;
                     tdat_d = head_dat;
                  end
               end
               COUNT: begin
                  if (tmr_q != '0) begin
                     tmr_d = tmr_q - DLY_W'(1);
                  end else if (!empty) begin
                     tmr_d  = head_dly;
                     tdat_d = head_dat;
                  end else begin
                     st_d = IDLE;
                  end
               end
               default: st_d = IDLE;
            endcase
         end
      end

      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
         if (!S_AXI_ARESETN) begin
            st_q   <= IDLE;
            tmr_q  <= '0;
            tdat_q <= '0;
         end else begin
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            tdat_q <= tdat_d;
         end
      end

      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
         if (!S_AXI_ARESETN) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
         end else if (flush || imm) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (wr)  wp_q <= wp_q + AW'(1);
            if (pop) rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + CW'(wr) - CW'(pop);
         end
      end

      // The output register holds the last released value; flush leaves it alone.
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
         if (!S_AXI_ARESETN) begin
            out_q <= '0;
            stb_q <= 1'b0;
         end else if (imm) begin
            out_q <= in_data_i;
            stb_q <= 1'b1;
         end else if (rel) begin
            out_q <= tdat_q;
            stb_q <= 1'b1;
         end else begin
            stb_q <= 1'b0;
         end
      end

      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
         if (!S_AXI_ARESETN) begin
            ovf_q <= 1'b0;
         end else if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (err_clr_i) begin
            ovf_q <= 1'b0;
         end
      end

      assign data_o[k*DATA_W +: DATA_W] = out_q;
      assign stb_o[k] = stb_q;
      assign ovf_o[k] = ovf_q;

`ifdef FLO_TIMED_BUFS_OCC_EN
      assign occ_o[k*CW +: CW] = cnt_q;
      assign busy_v[k] = (st_q == COUNT) || !empty;
`endif
   end

endmodule

// File: tb/tb_flo_timed_bufs.sv
// Directed bench for flo_timed_bufs: one drop-mode and one backpressure-mode instance.
// Strobes are logged per channel with their edge number and compared against hand-derived timing.
module tb_flo_timed_bufs;

   localparam int NCH = 24;
   localparam int DW  = 16;
   localparam int LW  = 8;
   localparam int CHW = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic           in_valid = 1'b0, in_imm = 1'b0, hold = 1'b0, err_clr = 1'b0;
   logic [CHW-1:0] in_chan = '0;
   logic [LW-1:0]  in_delay = '0;
   logic [DW-1:0]  in_data = '0;
   logic [NCH-1:0] flush = '0;
   logic           b_valid = 1'b0;
   logic [CHW-1:0] b_chan = '0;
   logic [LW-1:0]  b_delay = '0;
   logic [DW-1:0]  b_data = '0;

   logic              ready0, ready1, badch0, badch1;
   logic [NCH*DW-1:0] data0, data1;
   logic [NCH-1:0]    stb0, stb1, ovf0, ovf1;
`ifdef FLO_TIMED_BUFS_OCC_EN
   logic [NCH*3-1:0]  occ0, occ1;
   logic              busy0, busy1;
`endif

   flo_timed_bufs #(.NCH(NCH), .DATA_W(DW), .DLY_W(LW), .DEPTH(4), .BACKPRESSURE(0)) dut0 (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .in_valid_i(in_valid), .in_ready_o(ready0), .in_chan_i(in_chan),
      .in_delay_i(in_delay), .in_data_i(in_data), .in_imm_i(in_imm),
      .hold_i(hold), .flush_i(flush), .err_clr_i(err_clr),
      .data_o(data0), .stb_o(stb0), .ovf_o(ovf0), .badch_o(badch0)
`ifdef FLO_TIMED_BUFS_OCC_EN
      , .occ_o(occ0), .busy_o(busy0)
`endif
   );

   flo_timed_bufs #(.NCH(NCH), .DATA_W(DW), .DLY_W(LW), .DEPTH(4), .BACKPRESSURE(1)) dut1 (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .in_valid_i(b_valid), .in_ready_o(ready1), .in_chan_i(b_chan),
      .in_delay_i(b_delay), .in_data_i(b_data), .in_imm_i(in_imm),
      .hold_i(hold), .flush_i(flush), .err_clr_i(err_clr),
      .data_o(data1), .stb_o(stb1), .ovf_o(ovf1), .badch_o(badch1)
`ifdef FLO_TIMED_BUFS_OCC_EN
      , .occ_o(occ1), .busy_o(busy1)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Strobe log: [dut][channel][event]
   int            ev_n   [2][NCH];
   int            ev_cyc [2][NCH][8];
   logic [DW-1:0] ev_dat [2][NCH][8];
   logic          ev_clear = 1'b0;

   always @(negedge clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (ev_clear) begin
            ev_n[0][k] = 0;
            ev_n[1][k] = 0;
         end else begin
            if (stb0[k]) begin
               if (ev_n[0][k] < 8) begin
                  ev_cyc[0][k][ev_n[0][k]] = cyc;
                  ev_dat[0][k][ev_n[0][k]] = data0[k*DW +: DW];
               end
               ev_n[0][k]++;
            end
            if (stb1[k]) begin
               if (ev_n[1][k] < 8) begin
                  ev_cyc[1][k][ev_n[1][k]] = cyc;
                  ev_dat[1][k][ev_n[1][k]] = data1[k*DW +: DW];
               end
               ev_n[1][k]++;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_ev();
      ev_clear = 1'b1;
      @(negedge clk);
      #1 ev_clear = 1'b0;
      step(1);
   endtask

   task automatic send(input int ch, input int dly, input logic [DW-1:0] dat, input logic imm);
      in_valid = 1'b1;
      in_chan  = ch[CHW-1:0];
      in_delay = dly[LW-1:0];
      in_data  = dat;
      in_imm   = imm;
      step(1);
      in_valid = 1'b0;
      in_imm   = 1'b0;
   endtask

   int e0, ew5, i0, i1, n;
   logic acc1, stall;

   initial begin
      for (int k = 0; k < NCH; k++) begin
         ev_n[0][k] = 0;
         ev_n[1][k] = 0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_data", data0, '0);
      check("rst_stb", stb0, '0);
      check("rst_ovf", ovf0, '0);
      check("rst_badch", badch0, 1'b0);
      check("rst_ready0", ready0, 1'b1);
      check("rst_ready1", ready1, 1'b1);
`ifdef FLO_TIMED_BUFS_OCC_EN
      check("rst_busy", busy0, 1'b0);
      check("rst_occ", occ0, '0);
`endif
      rst_n = 1'b1;
      step(2);
      clear_ev();

      // Staggered delays align all 24 releases on edge e0+26
      for (int k = 0; k < NCH; k++) begin
         send(k, 24 - k, 16'(32'hde00 + k), 1'b0);
         if (k == 0) e0 = cyc;
      end
      step(10);
      for (int k = 0; k < NCH; k++) begin
         check($sformatf("align_n%0d", k), ev_n[0][k], 1);
         check($sformatf("align_cyc%0d", k), ev_cyc[0][k][0], e0 + 26);
         check($sformatf("align_dat%0d", k), ev_dat[0][k][0], 16'(32'hde00 + k));
      end
      check("align_hold5", data0[5*DW +: DW], 16'hde05);
      clear_ev();

      // Burst: delay 70 then three zero-delay words per channel
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < NCH; k++) begin
            send(k, (w == 0) ? 70 : 0, {8'(17 * (w + 1)), 8'(k)}, 1'b0);
            if (w == 0 && k == 0) e0 = cyc;
         end
      end
      step(10);
      for (int k = 0; k < NCH; k++) begin
         check($sformatf("burst_n%0d", k), ev_n[0][k], 4);
         for (int w = 0; w < 4; w++) begin
            check($sformatf("burst_cyc%0d_%0d", k, w), ev_cyc[0][k][w], e0 + k + 72 + w);
            check($sformatf("burst_dat%0d_%0d", k, w), ev_dat[0][k][w], {8'(17 * (w + 1)), 8'(k)});
         end
      end
      clear_ev();

      // Overflow on channel 1: drop mode (dut0) vs backpressure (dut1)
      i0 = 0; i1 = 0; n = 0; stall = 1'b0; e0 = 0; ew5 = 0;
      while (i1 < 6 && n < 100) begin
         in_valid = (i0 < 6);
         in_chan  = 5'd1;
         in_delay = 8'd9;
         in_data  = 16'(32'hccc0 + i0);
         b_valid  = 1'b1;
         b_chan   = 5'd1;
         b_delay  = 8'd9;
         b_data   = 16'(32'hccc0 + i1);
         #1;
         acc1 = ready1;
         if (!ready1) stall = 1'b1;
         if (n == 5) check("ready0_full", ready0, 1'b1);
         if (n == 5) check("ready1_full", ready1, 1'b0);
         @(posedge clk);
         #1;
         if (n == 0) e0 = cyc;
         if (acc1 && i1 == 5) ew5 = cyc;
         if (in_valid) i0++;
         if (acc1) i1++;
         n++;
      end
      in_valid = 1'b0;
      b_valid  = 1'b0;
      check("bp_all_accepted", i1, 6);
      check("bp_stalled", stall, 1'b1);
      check("bp_w5_edge", ew5, e0 + 11);
      step(60);
      check("ovf0", ovf0, 24'h2);
      check("ovf1", ovf1, 24'h0);
      check("drop_n", ev_n[0][1], 5);
      check("bp_n", ev_n[1][1], 6);
      for (int w = 0; w < 5; w++) begin
         check($sformatf("drop_cyc%0d", w), ev_cyc[0][1][w], e0 + 11 + 10 * w);
         check($sformatf("drop_dat%0d", w), ev_dat[0][1][w], 16'(32'hccc0 + w));
      end
      for (int w = 0; w < 6; w++) begin
         check($sformatf("bp_cyc%0d", w), ev_cyc[1][1][w], e0 + 11 + 10 * w);
         check($sformatf("bp_dat%0d", w), ev_dat[1][1][w], 16'(32'hccc0 + w));
      end
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("ovf_clr", ovf0, 24'h0);
      clear_ev();

      // Immediate write discards pending words on channel 0
      for (int w = 0; w < 3; w++) send(0, 20, 16'(32'h0a00 + w), 1'b0);
      send(0, 0, 16'hdead, 1'b1);
      e0 = cyc;
      step(40);
      check("imm_n", ev_n[0][0], 1);
      check("imm_cyc", ev_cyc[0][0][0], e0);
      check("imm_dat", ev_dat[0][0][0], 16'hdead);
      check("imm_hold", data0[0 +: DW], 16'hdead);
      clear_ev();

      // Hold for 20 edges mid-countdown pushes release from e0+12 to e0+32
      send(2, 10, 16'h5a5a, 1'b0);
      e0 = cyc;
      step(3);
      hold = 1'b1;
      step(20);
      hold = 1'b0;
      step(30);
      check("hold_n", ev_n[0][2], 1);
      check("hold_cyc", ev_cyc[0][2][0], e0 + 32);
      check("hold_dat", ev_dat[0][2][0], 16'h5a5a);
      clear_ev();

      // Flush a full channel together with a write: no strobe, no overflow
      for (int w = 0; w < 5; w++) send(3, 50, 16'(32'h3300 + w), 1'b0);
      flush = 24'h8;
      send(3, 0, 16'h2222, 1'b0);
      flush = '0;
      step(60);
      check("flush_n", ev_n[0][3], 0);
      check("flush_ovf", ovf0[3], 1'b0);
      check("flush_data", data0[3*DW +: DW], 16'h4403);
      clear_ev();

      // Bad channel index; set beats simultaneous clear
      send(30, 0, 16'h7777, 1'b0);
      check("badch_set", badch0, 1'b1);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("badch_clr", badch0, 1'b0);
      err_clr = 1'b1;
      send(31, 0, 16'h7778, 1'b0);
      err_clr = 1'b0;
      check("badch_set_wins", badch0, 1'b1);
      step(5);
      check("badch_no_stb", ev_n[0][0] + ev_n[0][23], 0);

      // Reset mid-burst clears everything asynchronously
      for (int w = 0; w < 6; w++) send(7, 200, 16'(32'h7700 + w), 1'b0);
      check("pre_rst_ovf", ovf0, 24'h80);
      for (int w = 0; w < 4; w++) send(4, 0, 16'(32'h4400 + w), 1'b0);
      check("pre_rst_stb", stb0[4], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_data", data0, '0);
      check("arst_stb", stb0, '0);
      check("arst_ovf", ovf0, '0);
      check("arst_badch", badch0, 1'b0);
      step(2);
      rst_n = 1'b1;
      clear_ev();
      step(20);
      check("post_rst_n4", ev_n[0][4], 0);
      check("post_rst_n7", ev_n[0][7], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
